i2c_slave_rx: RTL and testbench
===============================

Name: i2c_slave_rx

Overview:
- I2C target (slave) receiver: the responding end of the bus driven by the team's I2C master transmitter.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address, ACKs write transactions and delivers each received byte to fabric logic with a valid/ready handshake.
- Write-only target: read requests are NACKed.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit address this target responds to.

Ports:
- clk  input  1  system clock, at least 8x SCL frequency.
- reset  input  1  synchronous, active-high reset.
- scl_in  input  1  raw SCL from pad (asynchronous).
- sda_in  input  1  raw SDA from pad (asynchronous).
- sda_oe  output  1  1 = pull SDA low (open-drain ACK); 0 = release.
- rx_data  output  8  last received data byte, MSB = first bit on wire.
- rx_valid  output  1  one-clk pulse; rx_data is valid in that cycle.
- rx_ready  input  1  fabric can accept a byte; sampled when a byte completes.
- rx_start  output  1  one-clk pulse on an addressed-write start (after address ACK decision).
- rx_stop  output  1  one-clk pulse on STOP ending an addressed transaction.
- addr_match  output  1  high from address ACK until next START/STOP.
- busy  output  1  high between any START and STOP on the bus.

Behaviour:
- Reset: sda_oe=0, rx_data=8'h00, rx_valid=0, rx_start=0, rx_stop=0, addr_match=0, busy=0, state=IDLE, bit count=0.
- Input conditioning:
  - scl_in/sda_in pass through 2-flop synchronizers giving scl_s/sda_s, plus one history flop each giving scl_d/sda_d.
  - scl_rise = scl_s & ~scl_d; scl_fall = ~scl_s & scl_d.
  - START = scl_s & scl_d & sda_d & ~sda_s.
  - STOP = scl_s & scl_d & ~sda_d & sda_s.
- Priority: START/STOP override all states. A bit edge and START/STOP cannot coincide by construction.
- START (incl. repeated):
  - state->ADDR, bit count=0, shift reg cleared, sda_oe=0, addr_match=0, busy=1.
- STOP:
  - state->IDLE, sda_oe=0, addr_match=0, busy=0.
  - rx_stop pulses one clk if addr_match was 1.
- Bits are sampled into an MSB-first shift register on scl_rise, in ADDR and DATA only.
- States:
  - IDLE: wait for START.
  - ADDR: on the 8th scl_rise, compare shift[7:1] with SLAVE_ADDR; shift[0] is R/W.
    - Match and R/W=0: ack_pending=1, addr_match=1, rx_start pulses on the following clk; next scl_fall -> ACK.
    - Otherwise -> IGNORE (no drive).
  - ACK: entered on scl_fall after the 8th bit, with sda_oe=1 if ack_pending. Held through the 9th SCL high. On the next scl_fall: sda_oe=0, bit count=0, ->DATA (if addressed) else ->IGNORE.
  - DATA: on the 8th scl_rise, the byte completes.
    - If rx_ready=1: rx_data<=byte and rx_valid=1 on the next clk; ack_pending=1.
    - If rx_ready=0: ack_pending=0 (NACK); byte dropped, rx_data unchanged, no rx_valid; after the ACK slot -> IGNORE.
  - IGNORE: sda_oe=0, ignore SCL until START/STOP.
- Latency:
  - scl_in pin edge to internal edge detect: 3 clks.
  - rx_valid asserts 1 clk after the detected 8th data rise, before the ACK slot.
- sda_oe never changes while scl_s=1, except being forced to 0 by STOP/START.
- Bit counter is 4 bits and saturates at 8; it is never allowed to wrap within a byte.
- Reset mid-transaction: immediate return to reset values. The bus is released even if the ACK slot is in progress.

Test Plan:
- Write to 7'h50 with data 8'hA7, 8'h3C, then STOP, rx_ready=1 -> address byte ACKed (sda_oe=1 during 9th SCL); rx_start pulse; rx_valid pulses twice with rx_data 8'hA7 then 8'h3C, each ACKed; rx_stop pulse; busy/addr_match drop.
- Address 7'h51 write -> sda_oe stays 0 for whole transfer; no rx_start/rx_valid/rx_stop; busy high START..STOP.
- Address 7'h50 with R/W=1 -> NACK, addr_match=0, state IGNORE until STOP.
- rx_ready=0 during 2nd data byte 8'h55 -> first byte ACKed and delivered; 8'h55 NACKed, no rx_valid, rx_data holds first byte; following clocks ignored until STOP.
- Repeated START after one data byte, then address 7'h50 again and byte 8'h01 -> second rx_start pulse, byte 8'h01 delivered; no rx_stop between the two transactions.
- Assert reset while sda_oe=1 in an ACK slot -> next clk all outputs at reset values, SDA released; a later full write to 7'h50 works normally.

Source files
------------

// File: rtl/i2c_slave_rx.sv
// I2C write-only target receiver.
// Oversamples SCL/SDA on the system clock, detects START/repeated START/STOP,
// ACKs writes to SLAVE_ADDR and hands each received byte to the fabric with a
// valid/ready handshake. Read requests and other addresses are NACKed.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_start,
  output logic       rx_stop,
  output logic       addr_match,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK,
    ST_DATA,
    ST_IGNORE
  } state_t;

  // Input conditioning: two-flop synchronizers plus one history flop each.
  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_d;
  logic       r_sda_d;

  logic w_scl_s;
  logic w_sda_s;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  // Receiver state.
  state_t     r_state;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_ack_pending;
  logic       r_sda_oe;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_rx_start;
  logic       r_rx_stop;
  logic       r_addr_match;
  logic       r_busy;

  logic       w_bit_done;
  logic       w_last_bit;
  logic [7:0] w_next_byte;

  assign w_scl_s    = r_scl_sync[1];
  assign w_sda_s    = r_sda_sync[1];
  assign w_scl_rise = w_scl_s & ~r_scl_d;
  assign w_scl_fall = ~w_scl_s & r_scl_d;
  assign w_start    = w_scl_s & r_scl_d & r_sda_d & ~w_sda_s;
  assign w_stop     = w_scl_s & r_scl_d & ~r_sda_d & w_sda_s;

  // Bit counter saturates at 8, so "byte complete" is a plain compare.
  assign w_bit_done  = (r_bit_cnt == 4'd8);
  assign w_last_bit  = (r_bit_cnt == 4'd7);
  assign w_next_byte = {r_shift[6:0], w_sda_s};

  // Synchronize the pad inputs and keep one cycle of history for edge detection.
  // NOTE: synchronizers reset to 1 (idle bus) so leaving reset never fakes a START/STOP edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value.
      r_scl_sync <= {r_scl_sync[0], scl_in};
      r_sda_sync <= {r_sda_sync[0], sda_in};
      r_scl_d    <= r_scl_sync[1];
      r_sda_d    <= r_sda_sync[1];
    end
  end

  // Protocol FSM: START/STOP take priority, otherwise shift bits and run the ACK slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= 4'd0;
      r_shift       <= 8'h00;
      r_ack_pending <= 1'b0;
      r_sda_oe      <= 1'b0;
      r_rx_data     <= 8'h00;
      r_rx_valid    <= 1'b0;
      r_rx_start    <= 1'b0;
      r_rx_stop     <= 1'b0;
      r_addr_match  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      // Single-cycle strobes default low.
      r_rx_valid <= 1'b0;
      r_rx_start <= 1'b0;
      r_rx_stop  <= 1'b0;

      if (w_start) begin
        r_state       <= ST_ADDR;
        r_bit_cnt     <= 4'd0;
        r_shift       <= 8'h00;
        r_ack_pending <= 1'b0;
        r_sda_oe      <= 1'b0;
        r_addr_match  <= 1'b0;
        r_busy        <= 1'b1;
      end else if (w_stop) begin
        r_state       <= ST_IDLE;
        r_ack_pending <= 1'b0;
        r_sda_oe      <= 1'b0;
        r_addr_match  <= 1'b0;
        r_busy        <= 1'b0;
        r_rx_stop     <= r_addr_match;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_sda_oe <= 1'b0;
          end

          ST_ADDR, ST_DATA: begin
            if (w_scl_rise && !w_bit_done) begin
              r_shift   <= w_next_byte;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (w_last_bit) begin
                if (r_state == ST_ADDR) begin
                  // Only a write to our address is acknowledged.
                  if ((w_next_byte[7:1] == SLAVE_ADDR) && !w_next_byte[0]) begin
                    r_ack_pending <= 1'b1;
                    r_addr_match  <= 1'b1;
                    r_rx_start    <= 1'b1;
                  end else begin
                    r_ack_pending <= 1'b0;
                    r_state       <= ST_IGNORE;
                  end
                end else if (rx_ready) begin
                  r_rx_data     <= w_next_byte;
                  r_rx_valid    <= 1'b1;
                  r_ack_pending <= 1'b1;
                end else begin
                  // Fabric cannot take the byte: drop it and NACK.
                  r_ack_pending <= 1'b0;
                end
              end
            end else if (w_scl_fall && w_bit_done) begin
              // SCL is low here, so driving SDA cannot disturb the bus.
              r_state  <= ST_ACK;
              r_sda_oe <= r_ack_pending;
            end
          end

          ST_ACK: begin
            // Hold the ACK level through the 9th SCL high, release on its falling edge.
            if (w_scl_fall) begin
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= 4'd0;
              r_shift   <= 8'h00;
              r_state   <= r_ack_pending ? ST_DATA : ST_IGNORE;
            end
          end

          ST_IGNORE: begin
            r_sda_oe <= 1'b0;
          end

          default: begin
            r_state  <= ST_IDLE;
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe     = r_sda_oe;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign rx_start   = r_rx_start;
  assign rx_stop    = r_rx_stop;
  assign addr_match = r_addr_match;
  assign busy       = r_busy;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Self-checking bench for i2c_slave_rx: a bus-master model drives SCL/SDA on a
// wired-AND bus, a scoreboard queue holds the bytes the target must deliver.
module tb_i2c_slave_rx;

  localparam int Q = 8;  // system clocks per quarter SCL period

  logic       clk;
  logic       reset;
  logic       m_scl;
  logic       m_sda;
  logic       rx_ready;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_start;
  logic       rx_stop;
  logic       addr_match;
  logic       busy;
  logic       sda_bus;

  assign sda_bus = m_sda & ~sda_oe;

  i2c_slave_rx #(.SLAVE_ADDR(7'h50)) dut (
    .clk        (clk),
    .reset      (reset),
    .scl_in     (m_scl),
    .sda_in     (sda_bus),
    .sda_oe     (sda_oe),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_start   (rx_start),
    .rx_stop    (rx_stop),
    .addr_match (addr_match),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_start  = 0;
  int n_stop   = 0;
  int n_valid  = 0;
  int oe_high  = 0;
  int oe_viol  = 0;
  logic prev_oe = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: scoreboard pops, pulse counters, SDA-drive discipline.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if ((sda_oe !== prev_oe) && m_scl) oe_viol++;
      if (sda_oe) oe_high++;
      if (rx_start) n_start++;
      if (rx_stop) n_stop++;
      if (rx_valid) begin
        n_valid++;
        if (exp_q.size() == 0) check("unexpected_rx_valid", 32'd1, 32'd0);
        else check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_oe = sda_oe;
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clear_counts();
    n_start = 0;
    n_stop  = 0;
    n_valid = 0;
    oe_high = 0;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic i2c_rep_start();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; wait_q();
      m_scl = 1'b1; wait_q(); wait_q();
      m_scl = 1'b0; wait_q();
    end
  endtask

  // Sends one byte and returns whether the target pulled SDA low in the 9th clock.
  task automatic write_byte(input logic [7:0] b, output logic acked);
    send_bits(b);
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    acked = ~sda_bus;
    wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_sda_oe"},     {31'd0, sda_oe},     32'd0);
    check({pfx, "_rx_data"},    {24'd0, rx_data},    32'd0);
    check({pfx, "_rx_valid"},   {31'd0, rx_valid},   32'd0);
    check({pfx, "_rx_start"},   {31'd0, rx_start},   32'd0);
    check({pfx, "_rx_stop"},    {31'd0, rx_stop},    32'd0);
    check({pfx, "_addr_match"}, {31'd0, addr_match}, 32'd0);
    check({pfx, "_busy"},       {31'd0, busy},       32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack;
    reset = 1'b1; m_scl = 1'b1; m_sda = 1'b1; rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Addressed write of two bytes, both accepted.
    clear_counts();
    i2c_start();
    check("t1_busy_after_start", {31'd0, busy}, 32'd1);
    write_byte(8'hA0, ack);
    check("t1_addr_ack", {31'd0, ack}, 32'd1);
    check("t1_addr_match", {31'd0, addr_match}, 32'd1);
    exp_q.push_back(8'hA7);
    write_byte(8'hA7, ack);
    check("t1_data0_ack", {31'd0, ack}, 32'd1);
    exp_q.push_back(8'h3C);
    write_byte(8'h3C, ack);
    check("t1_data1_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    check("t1_busy_after_stop", {31'd0, busy}, 32'd0);
    check("t1_addr_match_after_stop", {31'd0, addr_match}, 32'd0);
    check("t1_rx_data_held", {24'd0, rx_data}, 32'h3C);
    check("t1_start_pulses", n_start, 1);
    check("t1_valid_pulses", n_valid, 2);
    check("t1_stop_pulses", n_stop, 1);

    // Write to another address: target stays silent.
    clear_counts();
    i2c_start();
    write_byte(8'hA2, ack);
    check("t2_addr_nack", {31'd0, ack}, 32'd0);
    write_byte(8'h12, ack);
    check("t2_data_nack", {31'd0, ack}, 32'd0);
    check("t2_busy_mid", {31'd0, busy}, 32'd1);
    i2c_stop();
    check("t2_busy_after_stop", {31'd0, busy}, 32'd0);
    check("t2_oe_never_high", oe_high, 0);
    check("t2_no_events", n_start + n_valid + n_stop, 0);

    // Read from our address: NACKed and ignored.
    clear_counts();
    i2c_start();
    write_byte(8'hA1, ack);
    check("t3_read_nack", {31'd0, ack}, 32'd0);
    check("t3_addr_match", {31'd0, addr_match}, 32'd0);
    write_byte(8'hFF, ack);
    i2c_stop();
    check("t3_oe_never_high", oe_high, 0);
    check("t3_no_events", n_start + n_valid + n_stop, 0);

    // Fabric back-pressure on the second data byte.
    clear_counts();
    i2c_start();
    write_byte(8'hA0, ack);
    check("t4_addr_ack", {31'd0, ack}, 32'd1);
    exp_q.push_back(8'h9E);
    write_byte(8'h9E, ack);
    check("t4_data0_ack", {31'd0, ack}, 32'd1);
    rx_ready = 1'b0;
    write_byte(8'h55, ack);
    check("t4_data1_nack", {31'd0, ack}, 32'd0);
    check("t4_rx_data_held", {24'd0, rx_data}, 32'h9E);
    rx_ready = 1'b1;
    write_byte(8'h77, ack);
    check("t4_ignored_nack", {31'd0, ack}, 32'd0);
    i2c_stop();
    check("t4_start_pulses", n_start, 1);
    check("t4_valid_pulses", n_valid, 1);
    check("t4_stop_pulses", n_stop, 1);

    // Repeated START between two addressed writes.
    clear_counts();
    i2c_start();
    write_byte(8'hA0, ack);
    exp_q.push_back(8'hC3);
    write_byte(8'hC3, ack);
    i2c_rep_start();
    check("t5_busy_rep_start", {31'd0, busy}, 32'd1);
    check("t5_no_stop_between", n_stop, 0);
    write_byte(8'hA0, ack);
    check("t5_second_addr_ack", {31'd0, ack}, 32'd1);
    exp_q.push_back(8'h01);
    write_byte(8'h01, ack);
    check("t5_data_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    check("t5_start_pulses", n_start, 2);
    check("t5_valid_pulses", n_valid, 2);
    check("t5_stop_pulses", n_stop, 1);

    // Reset while the target is driving the ACK slot, then a normal write.
    clear_counts();
    i2c_start();
    send_bits(8'hA0);
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    check("t6_oe_in_ack_slot", {31'd0, sda_oe}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("t6_reset");
    check("t6_bus_released", {31'd0, sda_bus}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    clear_counts();
    i2c_start();
    write_byte(8'hA0, ack);
    check("t6_post_addr_ack", {31'd0, ack}, 32'd1);
    exp_q.push_back(8'h5A);
    write_byte(8'h5A, ack);
    check("t6_post_data_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    check("t6_start_pulses", n_start, 1);
    check("t6_valid_pulses", n_valid, 1);
    check("t6_stop_pulses", n_stop, 1);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("sda_oe_changed_while_scl_high", oe_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
